// File: rtl/al_hazard_fwd.sv
// Hazard detection and operand forwarding for the RVX in-order pipeline.
// Optional perf counters when AL_HAZ_PERF_EN is defined.
module al_hazard_fwd #(
    parameter int XLEN      = 32,
    parameter int RA_W      = 5,
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic            id_rs1_en,
    input  logic            id_rs2_en,
    input  logic [RA_W-1:0] id_rd,
    input  logic            id_we,
    input  logic            id_is_load,
    input  logic [XLEN-1:0] ex_rs1_data,
    input  logic [XLEN-1:0] ex_rs2_data,
    input  logic [XLEN-1:0] fwd_data1,
    input  logic [XLEN-1:0] fwd_data2,
    input  logic [XLEN-1:0] fwd_data3,
    input  logic            mem_ready,
    input  logic            flush,
    output logic [XLEN-1:0] ex_src_a,
    output logic [XLEN-1:0] ex_src_b,
    output logic            stall_if,
    output logic            stall_id,
    output logic            bubble_ex
`ifdef AL_HAZ_PERF_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_bubble_cnt
`endif
);
    localparam int N = FWD_DEPTH;

    if (FWD_DEPTH < 2 || FWD_DEPTH > 3) begin : g_bad_depth
        $error("al_hazard_fwd: FWD_DEPTH must be 2 or 3");
    end
    if (LOAD_LAT < 1 || LOAD_LAT > FWD_DEPTH - 1) begin : g_bad_lat
        $error("al_hazard_fwd: LOAD_LAT must be 1..FWD_DEPTH-1");
    end

    logic [N:0]      r_v;
    logic [N:0]      r_we;
    logic [N:0]      r_ld;
    logic [RA_W-1:0] r_rd [0:N];
    logic [RA_W-1:0] r_rs1;
    logic [RA_W-1:0] r_rs2;
    logic            r_rs1_en;
    logic            r_rs2_en;

    logic [XLEN-1:0] w_fwd [1:N];
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic            w_haz;
    logic            w_frz;
    logic            w_bub;
    logic            w_unused_ld;

    assign w_fwd[1] = fwd_data1;
    assign w_fwd[2] = fwd_data2;
    if (N == 3) begin : g_f3
        assign w_fwd[3] = fwd_data3;
    end else begin : g_nof3
        logic w_unused_fwd3;
        assign w_unused_fwd3 = ^fwd_data3;
    end
    assign w_unused_ld = r_ld[N];

    function automatic logic f_hit(
        input logic            v,
        input logic            we,
        input logic [RA_W-1:0] rd,
        input logic [RA_W-1:0] rs,
        input logic            en
    );
        return v & we & (rd != '0) & (rd == rs) & en;
    endfunction

    // Walk oldest to youngest so the youngest producer overrides.
    always_comb begin
        w_a = ex_rs1_data;
        w_b = ex_rs2_data;
        for (int k = N; k >= 1; k--) begin
            if (f_hit(r_v[k], r_we[k], r_rd[k], r_rs1, r_rs1_en))
                w_a = w_fwd[k];
            if (f_hit(r_v[k], r_we[k], r_rd[k], r_rs2, r_rs2_en))
                w_b = w_fwd[k];
        end
    end

    always_comb begin
        w_haz = 1'b0;
        for (int k = 0; k < LOAD_LAT; k++) begin
            if (r_ld[k] &&
                (f_hit(r_v[k], r_we[k], r_rd[k], id_rs1, id_rs1_en) ||
                 f_hit(r_v[k], r_we[k], r_rd[k], id_rs2, id_rs2_en)))
                w_haz = 1'b1;
        end
        w_haz = w_haz & id_valid;
    end

    assign w_frz     = ~mem_ready;
    assign w_bub     = mem_ready & ~flush & w_haz;
    assign stall_if  = rst & (w_frz | w_bub);
    assign stall_id  = rst & (w_frz | w_bub);
    assign bubble_ex = rst & w_bub;
    assign ex_src_a  = rst ? w_a : ex_rs1_data;
    assign ex_src_b  = rst ? w_b : ex_rs2_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_v      <= '0;
            r_we     <= '0;
            r_ld     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_rs1_en <= 1'b0;
            r_rs2_en <= 1'b0;
            for (int k = 0; k <= N; k++)
                r_rd[k] <= '0;
        end else if (mem_ready) begin
            for (int k = 1; k <= N; k++) begin
                r_v[k]  <= r_v[k-1];
                r_we[k] <= r_we[k-1];
                r_ld[k] <= r_ld[k-1];
                r_rd[k] <= r_rd[k-1];
            end
            if (flush || w_haz) begin
                r_v[0]   <= 1'b0;
                r_we[0]  <= 1'b0;
                r_ld[0]  <= 1'b0;
                r_rd[0]  <= '0;
                r_rs1    <= '0;
                r_rs2    <= '0;
                r_rs1_en <= 1'b0;
                r_rs2_en <= 1'b0;
            end else begin
                r_v[0]   <= id_valid;
                r_we[0]  <= id_we;
                r_ld[0]  <= id_is_load;
                r_rd[0]  <= id_rd;
                r_rs1    <= id_rs1;
                r_rs2    <= id_rs2;
                r_rs1_en <= id_rs1_en;
                r_rs2_en <= id_rs2_en;
            end
        end
    end

`ifdef AL_HAZ_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bub_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_bub_cnt   <= '0;
        end else begin
            if (stall_if && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (bubble_ex && r_bub_cnt != '1)
                r_bub_cnt <= r_bub_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt  = r_stall_cnt;
    assign perf_bubble_cnt = r_bub_cnt;
`endif

endmodule

// File: doc/al_hazard_fwd.md
# al_hazard_fwd

Parametrised hazard-detection and operand-forwarding unit for the RVX in-order pipeline. It keeps a shift register of destination tags for the instructions in ID/EX, EX/MEM, MEM/WB and (optionally) the retire stage. It selects EX-stage operands from the youngest valid producer. It inserts load-use bubbles sized to a configurable load latency and freezes on a data-memory wait handshake.

## Interface
- `XLEN`, 32, operand/result width
- `RA_W`, 5, register-address width
- `FWD_DEPTH`, 2, number of forwarding sources beyond EX: 2 = EX/MEM and MEM/WB, 3 = adds the retire stage
- `LOAD_LAT`, 1, forwarding stage from which load data is valid; legal 1..FWD_DEPTH-1, anything else is an elaboration error

- `clk` in 1 — clock
- `rst` in 1 — synchronous, active-low reset
- `id_valid` in 1 — ID holds a real instruction
- `id_rs1`, `id_rs2` in RA_W — ID source registers
- `id_rs1_en`, `id_rs2_en` in 1 — source is actually read
- `id_rd` in RA_W — ID destination register
- `id_we` in 1 — ID writes `id_rd`
- `id_is_load` in 1 — ID instruction is a load
- `ex_rs1_data`, `ex_rs2_data` in XLEN — register-file values latched in ID/EX
- `fwd_data1` in XLEN — EX/MEM result
- `fwd_data2` in XLEN — MEM/WB result
- `fwd_data3` in XLEN — retiring write data; ignored when FWD_DEPTH=2
- `mem_ready` in 1 — data memory accepts/returns this cycle; 0 freezes the pipe
- `flush` in 1 — branch redirect from EX; kills the ID instruction
- `ex_src_a`, `ex_src_b` out XLEN — forwarded EX operands
- `stall_if` out 1 — hold PC and IF/ID
- `stall_id` out 1 — hold ID
- `bubble_ex` out 1 — load invalid into ID/EX

## Operation
- Tag stage S0 = ID/EX; S1..S_FWD_DEPTH = EX/MEM, MEM/WB, retire. Each stage holds {valid, rd, we, is_load}. S0 also holds {rs1, rs1_en, rs2, rs2_en}.
- Producer match at Sk: valid & we & rd≠0 & rd==rs & rs_en.
- Forwarding (combinational, from S0):
  - `ex_src_a` takes the data of the lowest-k matching Sk, k=1..FWD_DEPTH, using `fwd_data{k}`.
  - If there is no match, `ex_src_a` = `ex_rs1_data`.
  - `ex_src_b` follows the same rule with rs2.
  - Youngest producer wins.
- Load hazard (combinational, from ID): id_valid and an ID source matches S_k with is_load and k < LOAD_LAT, k=0..LOAD_LAT-1.
- Priority per cycle: reset > freeze > flush > load hazard > advance.
  - **Freeze** (mem_ready=0): stall_if=stall_id=1, bubble_ex=0. All tags hold. A flush asserted during freeze is ignored; the requester holds it until mem_ready=1.
  - **Flush**: stall_if=stall_id=bubble_ex=0. S0 is loaded invalid and S1.. shift. A load hazard in the same cycle is discarded.
  - **Load hazard**: stall_if=stall_id=bubble_ex=1. S0 is loaded invalid and S1.. shift. The condition is re-evaluated every cycle, so LOAD_LAT=2 with a load in S0 gives 2 bubbles and with a load in S1 gives 1.
  - **Advance**: outputs 0. S0 loads the ID fields with valid=id_valid; S1..S_FWD_DEPTH shift by one.
- The oldest stage's tag falls off on advance, flush or bubble.

## Timing
- Forward select and stall outputs are combinational from tags plus ID inputs, with zero latency.
- Tags update on the rising `clk` edge.
- A load producer reaches its first legal forwarding source LOAD_LAT+1 cycles after issuing from ID.
- Reset, sampled on the clock edge with rst=0:
  - all tag valids cleared; all fields cleared
  - while rst=0, stall_if=stall_id=bubble_ex=0, and `ex_src_*` equals `ex_rs*_data`
  - the optional counter is cleared
- Reset mid-stall drops the stall on the same cycle; the first cycle after release advances.

## Configuration
- `AL_HAZ_PERF_EN` defined:
  - adds output `perf_stall_cnt` (32-bit) and output `perf_bubble_cnt` (32-bit)
  - `perf_stall_cnt` increments each cycle stall_if=1
  - `perf_bubble_cnt` increments each cycle bubble_ex=1
  - both counters are saturating, and both are cleared by reset
- `AL_HAZ_PERF_EN` undefined: no counters and no ports; behaviour is otherwise identical.

## Test plan
- EX→EX forward: `add x5` then `sub x6,x5,x5`, fwd_data1=0x11 → next cycle both ex_src_a and ex_src_b = 0x11, no stall.
- Priority: x5 written in S1 (0xAA) and in S2 (0xBB), consumer reads x5 → ex_src_a=0xAA. A consumer of x0 gets ex_rs1_data even if S1 has rd=0.
- Load-use, LOAD_LAT=1: `lw x7` then `add x8,x7,x0` → one cycle stall_if=bubble_ex=1, then ex_src_a=fwd_data2. With LOAD_LAT=2, FWD_DEPTH=3 → two bubbles, then ex_src_a=fwd_data3.
- Freeze: load hazard present with mem_ready=0 for 3 cycles → stall_if=1, bubble_ex=0, tags unchanged. When mem_ready returns to 1, exactly one bubble is inserted.
- Flush vs hazard: flush=1 coincident with a load hazard → stall_if=0, S0 invalid, and the next-cycle EX uses ex_rs data with no forwarding from the killed instruction.
- Reset mid-stall; with AL_HAZ_PERF_EN, perf counters: 5 load-use hazards then rst=0 for one edge → all outputs 0, tags invalid, perf_stall_cnt=0 (it was 5 before reset).
